// File: rtl/sym_deframer.sv
// Symbol deframer: hunts for an 8-bit sync word in a 2-bit symbol stream,
// then packs the following FRAME_LEN bytes MSB-first with one-cycle valid pulses.
module sym_deframer #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din_valid,
  input  logic [1:0] datain,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       sync_found,
  output logic       frame_done,
  output logic       locked,
  output logic [7:0] byte_idx,
  output logic       dbg_state
);

  // Handshake: a symbol is consumed on every rising edge where din_valid=1;
  // there is no backpressure. Output pulses are single-cycle and registered,
  // appearing the cycle after the edge that sampled the triggering symbol.

  typedef enum logic {
    S_HUNT    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] window_q, window_d;
  logic [5:0] shreg_q, shreg_d;
  logic [1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sync_found_q, sync_found_d;
  logic       frame_done_q, frame_done_d;

  logic [7:0] win_next;
  logic [7:0] byte_next;

  assign win_next  = {window_q[5:0], datain};
  assign byte_next = {shreg_q, datain};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HUNT;
      window_q     <= 8'h00;
      shreg_q      <= 6'h00;
      sym_cnt_q    <= 2'd0;
      byte_cnt_q   <= 8'd0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      shreg_q      <= shreg_d;
      sym_cnt_q    <= sym_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_found_q <= sync_found_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    shreg_d      = shreg_q;
    sym_cnt_d    = sym_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_found_d = 1'b0;
    frame_done_d = 1'b0;

    if (din_valid) begin
      case (state_q)
        S_HUNT: begin
          window_d = win_next;
          if (win_next == SYNC_WORD) begin
            sync_found_d = 1'b1;
            state_d      = S_PAYLOAD;
            sym_cnt_d    = 2'd0;
            byte_cnt_d   = 8'd0;
          end
        end
        S_PAYLOAD: begin
          shreg_d   = {shreg_q[3:0], datain};
          sym_cnt_d = sym_cnt_q + 2'd1;
          if (sym_cnt_q == 2'd3) begin
            dout_d       = byte_next;
            dout_valid_d = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              // Clearing the window stops a sync from straddling frame end.
              frame_done_d = 1'b1;
              state_d      = S_HUNT;
              window_d     = 8'h00;
              byte_cnt_d   = 8'd0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = S_HUNT;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_found = sync_found_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == S_PAYLOAD);
  assign byte_idx   = locked ? byte_cnt_q : 8'd0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sym_deframer.sv
// Directed, table-driven bench for sym_deframer: per-cycle expected outputs
// plus a byte scoreboard fed from the same table.
module tb_sym_deframer;

  logic       clk;
  logic       reset_n;
  logic       din_valid;
  logic [1:0] datain;
  logic [7:0] dout;
  logic       dout_valid;
  logic       sync_found;
  logic       frame_done;
  logic       locked;
  logic [7:0] byte_idx;
  logic       dbg_state;

  sym_deframer #(.SYNC_WORD(8'hA5), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din_valid  (din_valid),
    .datain     (datain),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sync_found (sync_found),
    .frame_done (frame_done),
    .locked     (locked),
    .byte_idx   (byte_idx),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       dv;
    logic [7:0] dout;
    logic       sf;
    logic       fd;
    logic       lk;
    logic [7:0] idx;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] hold;
  int         n_cmp;
  int         n_fail;
  int         n_pulse;
  int         n_exp_pulse;
  int         vec_no;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @vec %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] d, input logic dv, input logic [7:0] b,
                     input logic sf, input logic fd, input logic lk, input logic [7:0] idx);
    vec_t r;
    if (dv) begin
      hold = b;
      exp_q.push_back(b);
      n_exp_pulse++;
    end
    r.v = v; r.d = d; r.dv = dv; r.dout = hold;
    r.sf = sf; r.fd = fd; r.lk = lk; r.idx = idx;
    vecs.push_back(r);
  endtask

  task automatic hunt(input logic [1:0] d);
    add(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic sync4();
    hunt(2'd2); hunt(2'd2); hunt(2'd1);
    add(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic stall(input int n, input logic lk, input logic [7:0] idx);
    for (int i = 0; i < n; i++)
      add(1'b0, 2'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0, 1'b0, lk, idx);
  endtask

  task automatic pbyte(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] s3, input logic [7:0] idx, input logic [7:0] b,
                       input logic last);
    add(1'b1, s0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, idx);
    add(1'b1, s1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, idx);
    add(1'b1, s2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, idx);
    add(1'b1, s3, 1'b1, b, 1'b0, last, !last, last ? 8'd0 : idx + 8'd1);
  endtask

  task automatic basic_frame();
    pbyte(2'd0, 2'd3, 2'd3, 2'd0, 8'd0, 8'h3C, 1'b0);
    pbyte(2'd1, 2'd2, 2'd3, 2'd0, 8'd1, 8'h6C, 1'b0);
    pbyte(2'd3, 2'd3, 2'd3, 2'd3, 8'd2, 8'hFF, 1'b0);
    pbyte(2'd0, 2'd0, 2'd0, 2'd1, 8'd3, 8'h01, 1'b1);
  endtask

  // ---------------- driver ----------------
  task automatic run_vecs();
    foreach (vecs[i]) begin
      din_valid = vecs[i].v;
      datain    = vecs[i].d;
      @(posedge clk);
      #1;
      check("dout_valid", vec_no, {7'd0, dout_valid}, {7'd0, vecs[i].dv});
      check("dout",       vec_no, dout,               vecs[i].dout);
      check("sync_found", vec_no, {7'd0, sync_found}, {7'd0, vecs[i].sf});
      check("frame_done", vec_no, {7'd0, frame_done}, {7'd0, vecs[i].fd});
      check("locked",     vec_no, {7'd0, locked},     {7'd0, vecs[i].lk});
      check("dbg_state",  vec_no, {7'd0, dbg_state},  {7'd0, vecs[i].lk});
      check("byte_idx",   vec_no, byte_idx,           vecs[i].idx);
      vec_no++;
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hold    = 8'h00;
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'($urandom_range(0, 1));
      datain    = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      check("rst_dout",       i, dout, 8'h00);
      check("rst_dout_valid", i, {7'd0, dout_valid}, 8'd0);
      check("rst_sync_found", i, {7'd0, sync_found}, 8'd0);
      check("rst_frame_done", i, {7'd0, frame_done}, 8'd0);
      check("rst_locked",     i, {7'd0, locked},     8'd0);
      check("rst_byte_idx",   i, byte_idx, 8'd0);
    end
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && dout_valid === 1'b1) begin
      n_pulse++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_byte: got %h, want no pulse", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL sb_byte: got %h, want %h", dout, e);
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    n_cmp = 0; n_fail = 0; n_pulse = 0; n_exp_pulse = 0; vec_no = 0;
    hold = 8'h00;
    reset_n = 1'b0; din_valid = 1'b0; datain = 2'd0;
    #2;
    do_reset();

    // Junk before sync, then the basic frame.
    stall(1, 1'b0, 8'd0);
    hunt(2'd0); hunt(2'd3); hunt(2'd1); hunt(2'd2);
    sync4();
    basic_frame();

    // Overlapping sync candidate 2,2,2,2,1,1; payload carries A5 without resync.
    hunt(2'd2); hunt(2'd2);
    sync4();
    pbyte(2'd2, 2'd2, 2'd1, 2'd1, 8'd0, 8'hA5, 1'b0);
    pbyte(2'd1, 2'd1, 2'd2, 2'd2, 8'd1, 8'h5A, 1'b0);
    pbyte(2'd2, 2'd2, 2'd1, 2'd1, 8'd2, 8'hA5, 1'b0);
    pbyte(2'd3, 2'd0, 2'd3, 2'd0, 8'd3, 8'hCC, 1'b1);

    // Stalls: in hunt, mid-byte, and right after a valid pulse.
    hunt(2'd2); stall(2, 1'b0, 8'd0); hunt(2'd2); hunt(2'd1);
    add(1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd0);
    add(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
    stall(3, 1'b1, 8'd0);
    add(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 2'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd1);
    pbyte(2'd1, 2'd2, 2'd3, 2'd0, 8'd1, 8'h6C, 1'b0);
    stall(1, 1'b1, 8'd2);
    pbyte(2'd3, 2'd3, 2'd3, 2'd3, 8'd2, 8'hFF, 1'b0);
    pbyte(2'd0, 2'd0, 2'd0, 2'd1, 8'd3, 8'h01, 1'b1);

    // Back-to-back frames: sync immediately follows frame_done.
    sync4();
    basic_frame();
    sync4();
    pbyte(2'd0, 2'd1, 2'd0, 2'd1, 8'd0, 8'h11, 1'b0);
    pbyte(2'd0, 2'd2, 2'd0, 2'd2, 8'd1, 8'h22, 1'b0);
    pbyte(2'd0, 2'd3, 2'd0, 2'd3, 8'd2, 8'h33, 1'b0);
    pbyte(2'd1, 2'd0, 2'd1, 2'd0, 8'd3, 8'h44, 1'b1);
    run_vecs();

    // Reset in the middle of byte 1, then a fresh full frame.
    sync4();
    pbyte(2'd0, 2'd3, 2'd3, 2'd0, 8'd0, 8'h3C, 1'b0);
    add(1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1);
    run_vecs();
    do_reset();
    stall(1, 1'b0, 8'd0);
    hunt(2'd3); hunt(2'd0);
    sync4();
    basic_frame();
    stall(2, 1'b0, 8'd0);
    run_vecs();

    @(posedge clk);
    #1;
    check("sb_leftover", 0, 8'(exp_q.size()), 8'd0);
    check("pulse_count", 0, 8'(n_pulse), 8'(n_exp_pulse));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
